pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//   Hazard/stall/flush controller for the 5-stage RV32I pipeline. Watches IF/ID and ID/EX
//   fields, EX branch resolution and the MEM-stage data-memory handshake. Drives write-enables
//   and flushes of PC, IF/ID, ID/EX and EX/MEM, with a data-memory timeout trap and
//   saturating performance counters.
// PARAMETERS
//   MEM_TIMEOUT  16  consecutive dmem wait cycles before trapping; 0 disables the timeout
//   CNT_W        32  width of the performance counters
// PORTS
//   clk             in   1      pipeline clock
//   rst             in   1      asynchronous, active-high reset
//   if_id_rs1       in   5      instr[19:15] of the instruction in IF/ID
//   if_id_rs2       in   5      instr[24:20] of the instruction in IF/ID
//   if_id_opcode    in   7      instr[6:0] of the instruction in IF/ID
//   id_ex_rd        in   5      rd latched in ID/EX
//   id_ex_opcode    in   7      opcode latched in ID/EX
//   ex_redirect     in   1      branch taken or JAL/JALR resolved in EX this cycle
//   dmem_req        in   1      MEM stage holds a load/store this cycle
//   dmem_ready      in   1      data memory completes the access this cycle
//   pc_we           out  1      PC register update enable
//   if_id_we        out  1      IF/ID register load enable
//   if_id_flush     out  1      IF/ID register loads a NOP (0x00000013)
//   id_ex_flush     out  1      ID/EX register loads a bubble (opcode 0, rd 0)
//   ex_mem_we       out  1      EX/MEM and MEM/WB register load enable
//   ctrl_state      out  2      FSM state (RUN=0, MEM_WAIT=1, TRAP=2)
//   mem_timeout_err out  1      sticky: dmem timeout occurred
//   stall_cycles    out  CNT_W  saturating count of stall cycles (load-use plus dmem wait)
//   flush_events    out  CNT_W  saturating count of redirect flushes
// BEHAVIOUR
//   - Reset (async): state=RUN, wait_cnt=0, counters=0, mem_timeout_err=0. While rst=1:
//     pc_we=if_id_we=ex_mem_we=0, if_id_flush=id_ex_flush=1.
//   - Register usage:
//     - rs1 is used unless opcode is LUI 0110111, AUIPC 0010111 or JAL 1101111.
//     - rs2 is used only for opcodes 0110011, 0100011 and 1100011.
//     - Register x0 never creates a hazard.
//   - load_use = (id_ex_opcode==0000011) & id_ex_rd!=0 & ((rs1 used & rs1==rd) | (rs2 used & rs2==rd)).
//   - freeze = dmem_req & ~dmem_ready.
//   - Outputs are combinational (Mealy) from state and inputs. Priority: TRAP > freeze > ex_redirect > load_use > normal.
//     - TRAP: all enables 0, no flushes; held until reset.
//     - freeze: all enables 0, no flushes. Pending redirect/load_use are re-evaluated on the release cycle.
//     - ex_redirect: pc_we=1, if_id_we=1, if_id_flush=1, id_ex_flush=1, ex_mem_we=1.
//       A redirect overrides a simultaneous load_use.
//     - load_use: pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1. Exactly 1 bubble per hazard.
//     - normal: all enables 1, flushes 0.
//   - FSM (registered):
//     - RUN -> MEM_WAIT on freeze.
//     - MEM_WAIT -> RUN when dmem_ready=1 or dmem_req=0; the release cycle uses normal priority rules.
//     - RUN/MEM_WAIT -> TRAP when freeze & MEM_TIMEOUT!=0 & wait_cnt==MEM_TIMEOUT-1.
//   - wait_cnt: increments on each freeze cycle, clears otherwise. Trap fires on the MEM_TIMEOUT-th consecutive freeze cycle.
//   - mem_timeout_err is set on entry to TRAP; it clears only on reset.
//   - Counters:
//     - stall_cycles +1 per cycle with (freeze | load_use), state!=TRAP.
//     - flush_events +1 per redirect cycle.
//     - Both saturate at all-ones; no wrap.
//   - Latency: hazard response is in the same cycle (0 latency). Counters and state update at the next clk edge.
// STRUCTURE
//   - pipe_pkg holds: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_OP, OP_LUI, OP_AUIPC, OP_JAL),
//     NOP encoding 32'h00000013, and the ctrl_state encoding RUN/MEM_WAIT/TRAP.
//   - Sub-module hazard_detect (combinational): computes rs usage and load_use from the IF/ID and ID/EX fields.
//   - The FSM, wait counter and perf counters live in pipeline_ctrl.
// TESTING
//   1. Load-use: id_ex LW rd=5, if_id ADD rs1=5
//      -> 1 cycle with pc_we=0, if_id_we=0, id_ex_flush=1; then normal; stall_cycles=1.
//   2. No hazard cases:
//      - rd=0, or LUI in IF/ID with rs1 field==rd -> load_use=0, all enables 1.
//      - ADDI rs2 field==rd -> no stall.
//   3. Redirect with simultaneous load_use
//      -> if_id_flush=1, id_ex_flush=1, pc_we=1 for 1 cycle; flush_events=1; no stall counted.
//   4. dmem_req=1, dmem_ready=0 for 3 cycles, then ready
//      -> 3 cycles all enables 0, ctrl_state=1; back to RUN; stall_cycles=3.
//   5. MEM_TIMEOUT=4, ready held 0
//      -> on the 4th freeze cycle's edge ctrl_state=2, mem_timeout_err=1, enables stay 0 until rst.
//   6. Assert rst asynchronously mid-MEM_WAIT
//      -> immediate flushes=1, enables 0; counters and err=0; RUN after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared opcode constants, state encoding and register-usage helpers for the
// RV32I pipeline hazard/stall/flush controller.
package pipe_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } ctrl_state_e;

  // U-type and JAL carry immediate bits in the rs1 field.
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_OP || opcode == OP_STORE || opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline-side fields observed by the controller and the stage enables/flushes
// it drives back. master = datapath, slave = controller.
interface pipeline_ctrl_if;
  logic [4:0] if_id_rs1;
  logic [4:0] if_id_rs2;
  logic [6:0] if_id_opcode;
  logic [4:0] id_ex_rd;
  logic [6:0] id_ex_opcode;
  logic       ex_redirect;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_we;
  logic       if_id_we;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_we;

  modport master (
    output if_id_rs1, if_id_rs2, if_id_opcode, id_ex_rd, id_ex_opcode,
    output ex_redirect, dmem_req, dmem_ready,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we
  );

  modport slave (
    input  if_id_rs1, if_id_rs2, if_id_opcode, id_ex_rd, id_ex_opcode,
    input  ex_redirect, dmem_req, dmem_ready,
    output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detection between the instruction in IF/ID and a
// load sitting in ID/EX.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] if_id_rs1,
  input  logic [4:0] if_id_rs2,
  input  logic [6:0] if_id_opcode,
  input  logic [4:0] id_ex_rd,
  input  logic [6:0] id_ex_opcode,
  output logic       load_use
);

  logic rs1_used;
  logic rs2_used;
  logic rs1_match;
  logic rs2_match;

  assign rs1_used  = uses_rs1(if_id_opcode);
  assign rs2_used  = uses_rs2(if_id_opcode);
  assign rs1_match = rs1_used && (if_id_rs1 == id_ex_rd);
  assign rs2_match = rs2_used && (if_id_rs2 == id_ex_rd);

  // x0 is hardwired, so a load targeting it never produces a dependency.
  assign load_use = (id_ex_opcode == OP_LOAD) && (id_ex_rd != 5'd0) &&
                    (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: Mealy stage enables, RUN/MEM_WAIT/TRAP FSM with a
// data-memory timeout trap, and saturating stall/flush counters.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipeline_ctrl_if.slave   bus,
  output logic [1:0]       ctrl_state,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  ctrl_state_e       state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              err_reg;
  logic              load_use;
  logic              freeze;
  logic              trapped;
  logic              timeout_hit;

  logic pc_we_next;
  logic if_id_we_next;
  logic if_id_flush_next;
  logic id_ex_flush_next;
  logic ex_mem_we_next;

  hazard_detect u_hazard (
    .if_id_rs1    (bus.if_id_rs1),
    .if_id_rs2    (bus.if_id_rs2),
    .if_id_opcode (bus.if_id_opcode),
    .id_ex_rd     (bus.id_ex_rd),
    .id_ex_opcode (bus.id_ex_opcode),
    .load_use     (load_use)
  );

  assign freeze      = bus.dmem_req && !bus.dmem_ready;
  assign trapped     = (state_reg == TRAP);
  assign timeout_hit = (MEM_TIMEOUT != 0) &&
                       (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    pc_we_next       = 1'b1;
    if_id_we_next    = 1'b1;
    if_id_flush_next = 1'b0;
    id_ex_flush_next = 1'b0;
    ex_mem_we_next   = 1'b1;
    if (rst) begin
      pc_we_next       = 1'b0;
      if_id_we_next    = 1'b0;
      if_id_flush_next = 1'b1;
      id_ex_flush_next = 1'b1;
      ex_mem_we_next   = 1'b0;
    end else if (trapped || freeze) begin
      pc_we_next     = 1'b0;
      if_id_we_next  = 1'b0;
      ex_mem_we_next = 1'b0;
    end else if (bus.ex_redirect) begin
      // The wrong-path instructions in IF/ID and ID/EX are squashed, which
      // also discards any load-use dependency they carried.
      if_id_flush_next = 1'b1;
      id_ex_flush_next = 1'b1;
    end else if (load_use) begin
      pc_we_next       = 1'b0;
      if_id_we_next    = 1'b0;
      id_ex_flush_next = 1'b1;
    end
  end

  assign bus.pc_we       = pc_we_next;
  assign bus.if_id_we    = if_id_we_next;
  assign bus.if_id_flush = if_id_flush_next;
  assign bus.id_ex_flush = id_ex_flush_next;
  assign bus.ex_mem_we   = ex_mem_we_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        RUN, MEM_WAIT: begin
          if (freeze && timeout_hit) begin
            state_reg    <= TRAP;
            err_reg      <= 1'b1;
            wait_cnt_reg <= '0;
          end else if (freeze) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end else begin
            state_reg    <= RUN;
            wait_cnt_reg <= '0;
          end
        end
        TRAP: begin
          state_reg    <= TRAP;
          wait_cnt_reg <= '0;
        end
        default: begin
          state_reg    <= RUN;
          wait_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign ctrl_state      = state_reg;
  assign mem_timeout_err = err_reg;

  // Counters only advance for stalls and redirects that actually take effect.
  logic [1:0]       cnt_inc;
  logic [CNT_W-1:0] cnt_reg [2];

  assign cnt_inc[0] = !trapped && (freeze || (load_use && !bus.ex_redirect));
  assign cnt_inc[1] = !trapped && !freeze && bus.ex_redirect;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (cnt_inc[gi] && !(&cnt_reg[gi])) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cycles = cnt_reg[0];
  assign flush_events = cnt_reg[1];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a rule-level model
// of the stall/flush priorities, timeout trap and saturating counters.
module tb_pipeline_ctrl;
  import pipe_pkg::*;

  localparam int MT   = 4;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]    ctrl_state;
  logic          mem_timeout_err;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_events;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .ctrl_state      (ctrl_state),
    .mem_timeout_err (mem_timeout_err),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit m_trap;
  bit m_wait;
  bit m_err;
  int m_cnt;
  int m_stall;
  int m_flush;

  logic [6:0] op_tab [10];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".state"}, 32'(ctrl_state), m_trap ? 32'd2 : (m_wait ? 32'd1 : 32'd0));
    chk({tag, ".err"},   32'(mem_timeout_err), 32'(m_err));
    chk({tag, ".stall"}, 32'(stall_cycles), 32'(m_stall));
    chk({tag, ".flush"}, 32'(flush_events), 32'(m_flush));
  endtask

  task automatic set_idle();
    bus.if_id_rs1 = 0; bus.if_id_rs2 = 0; bus.if_id_opcode = 0;
    bus.id_ex_rd = 0; bus.id_ex_opcode = 0;
    bus.ex_redirect = 0; bus.dmem_req = 0; bus.dmem_ready = 0;
  endtask

  // One pipeline cycle: drive, check Mealy outputs mid-cycle, advance model, check registers.
  task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [6:0] ifop, input logic [4:0] rd, input logic [6:0] exop,
                      input bit redir, input bit req, input bit rdy);
    bit r1u, r2u, lu, fz;
    logic [4:0] e;   // {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we}
    bus.if_id_rs1 = rs1; bus.if_id_rs2 = rs2; bus.if_id_opcode = ifop;
    bus.id_ex_rd = rd; bus.id_ex_opcode = exop;
    bus.ex_redirect = redir; bus.dmem_req = req; bus.dmem_ready = rdy;
    r1u = !(ifop inside {7'b0110111, 7'b0010111, 7'b1101111});
    r2u = ifop inside {7'b0110011, 7'b0100011, 7'b1100011};
    lu  = (exop == 7'b0000011) && (rd != 0) && ((r1u && rs1 == rd) || (r2u && rs2 == rd));
    fz  = req && !rdy;
    if (m_trap || fz) e = 5'b00000;
    else if (redir)   e = 5'b11111;
    else if (lu)      e = 5'b00011;
    else              e = 5'b11001;
    @(negedge clk);
    chk({tag, ".ctl"}, 32'({bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush,
                             bus.ex_mem_we}), 32'(e));
    if (!m_trap) begin
      if (fz || (lu && !redir)) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (!fz && redir)         m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      if (fz) begin
        m_cnt++;
        if (m_cnt == MT) begin m_trap = 1; m_err = 1; end
        m_wait = 1;
      end else begin
        m_cnt = 0;
        m_wait = 0;
      end
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  // Asynchronous reset asserted between clock edges; called at posedge+1.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    set_idle();
    #1;
    chk({tag, ".rst_ctl"}, 32'({bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush,
                                 bus.ex_mem_we}), 32'b00110);
    m_trap = 0; m_wait = 0; m_err = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
    check_regs({tag, ".rst"});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_regs({tag, ".rel"});
  endtask

  initial begin
    op_tab = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011, 7'b0110111,
               7'b0010111, 7'b1101111, 7'b0010011, 7'b1100111, 7'b0000000};
    set_idle();
    m_trap = 0; m_wait = 0; m_err = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.ctl", 32'({bus.pc_we, bus.if_id_we, bus.if_id_flush, bus.id_ex_flush,
                          bus.ex_mem_we}), 32'b00110);
    check_regs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load-use: LW x5 in ID/EX, ADD rs1=x5 in IF/ID, then the bubble arrives
    step("lu_stall", 5, 0, OP_OP, 5, OP_LOAD, 0, 0, 0);
    step("lu_bubble", 5, 0, OP_OP, 0, 7'd0, 0, 0, 0);
    chk("lu.stall_cnt", 32'(stall_cycles), 32'd1);

    // No-hazard cases
    step("rd0", 0, 0, OP_OP, 0, OP_LOAD, 0, 0, 0);
    step("lui_rs1", 5, 0, OP_LUI, 5, OP_LOAD, 0, 0, 0);
    step("addi_rs2", 1, 5, OP_IMM, 5, OP_LOAD, 0, 0, 0);
    step("store_rs2", 1, 5, OP_STORE, 5, OP_LOAD, 0, 0, 0);
    chk("nohaz.stall_cnt", 32'(stall_cycles), 32'd2);

    // Redirect beats a simultaneous load-use
    step("redir_lu", 5, 0, OP_OP, 5, OP_LOAD, 1, 0, 0);
    chk("redir.flush_cnt", 32'(flush_events), 32'd1);
    chk("redir.stall_cnt", 32'(stall_cycles), 32'd2);

    // dmem wait for 3 cycles, then ready
    do_reset("t4");
    for (int i = 0; i < 3; i++) step("dwait", 0, 0, OP_OP, 0, 7'd0, 0, 1, 0);
    chk("dwait.state", 32'(ctrl_state), 32'd1);
    step("dready", 0, 0, OP_OP, 0, 7'd0, 0, 1, 1);
    chk("dready.state", 32'(ctrl_state), 32'd0);
    chk("dready.stall_cnt", 32'(stall_cycles), 32'd3);

    // Timeout after MT consecutive freeze cycles; trap is sticky
    do_reset("t5");
    for (int i = 0; i < MT; i++) step("tmo", 0, 0, OP_OP, 0, 7'd0, 1, 1, 0);
    chk("tmo.state", 32'(ctrl_state), 32'd2);
    chk("tmo.err", 32'(mem_timeout_err), 32'd1);
    step("trap_hold", 5, 0, OP_OP, 5, OP_LOAD, 1, 0, 0);
    step("trap_idle", 0, 0, OP_OP, 0, 7'd0, 0, 0, 0);

    // Reset in the middle of a memory wait
    do_reset("t6a");
    step("mw1", 0, 0, OP_OP, 0, 7'd0, 0, 1, 0);
    step("mw2", 0, 0, OP_OP, 0, 7'd0, 0, 1, 0);
    do_reset("t6");

    // Counter saturation
    for (int i = 0; i < CMAX + 4; i++) step("sat_lu", 3, 0, OP_BRANCH, 3, OP_LOAD, 0, 0, 0);
    chk("sat.stall_cnt", 32'(stall_cycles), 32'(CMAX));
    for (int i = 0; i < CMAX + 4; i++) step("sat_redir", 0, 0, OP_OP, 0, 7'd0, 1, 0, 0);
    chk("sat.flush_cnt", 32'(flush_events), 32'(CMAX));

    // Randomized traffic with periodic resets
    do_reset("rnd0");
    for (int i = 0; i < 800; i++) begin
      bit req;
      bit rdy;
      if (i % 60 == 59) do_reset("rnd_rst");
      req = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      step("rnd", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           op_tab[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
           op_tab[$urandom_range(0, 9)], ($urandom_range(0, 3) == 0), req, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
